// File: rtl/fir_ctrl.sv
// Stream controller around a pipelined FIR: forwards samples, appends TAPS zero beats per block,
// tracks results in flight and realigns the Q15 product. Define FIR_CTRL_SAT_EN to saturate on overflow.
module fir_ctrl #(
    parameter int DWIDTH  = 16,
    parameter int OWIDTH  = 2*DWIDTH,
    parameter int TAPS    = 8,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic [DWIDTH-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic              s_last,
    output logic [DWIDTH-1:0] f_data,
    output logic              f_valid,
    input  logic              f_ready,
    input  logic [OWIDTH-1:0] f_res,
    input  logic              f_res_valid,
    output logic              f_res_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_last,
    output logic              busy
);
    // state | meaning
    // IDLE  | waiting for en
    // RUN   | forwarding input samples into the filter
    // FLUSH | pushing TAPS zero samples to flush the filter pipeline
    // DRAIN | waiting for the remaining results to leave the filter
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

    localparam int CW = $clog2(MAX_OUT + 1);
    localparam int FW = $clog2(TAPS + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   out_cnt_q, out_cnt_d;
    logic [FW-1:0]   flush_cnt_q, flush_cnt_d;
    logic            full;
    logic            f_hs;
    logic            r_hs;
    logic [DWIDTH-1:0] m_trunc;
    logic            unused_res;

    assign full = (out_cnt_q == CW'(MAX_OUT));

    always_comb begin
        s_ready = 1'b0;
        f_valid = 1'b0;
        f_data  = '0;
        case (state_q)
            RUN: begin
                f_data  = s_data;
                f_valid = s_valid && !full;
                s_ready = f_ready && !full;
            end
            FLUSH:   f_valid = !full;
            default: ;
        endcase
    end

    assign f_hs        = f_valid && f_ready;
    assign r_hs        = f_res_valid && f_res_ready;
    assign f_res_ready = m_ready;
    assign m_valid     = f_res_valid;
    assign m_last      = m_valid && (state_q == DRAIN) && (out_cnt_q == CW'(1));
    assign busy        = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        out_cnt_d   = out_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (f_hs && !r_hs) begin
            out_cnt_d = out_cnt_q + CW'(1);
        end else if (r_hs && !f_hs) begin
            out_cnt_d = out_cnt_q - CW'(1);
        end
        case (state_q)
            IDLE: begin
                if (en) state_d = RUN;
            end
            RUN: begin
                if (s_valid && s_ready && s_last) begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                end
            end
            FLUSH: begin
                // counter parks at TAPS on the final zero beat rather than wrapping
                if (f_hs) begin
                    if (flush_cnt_q == FW'(TAPS - 1)) begin
                        flush_cnt_d = FW'(TAPS);
                        state_d     = DRAIN;
                    end else begin
                        flush_cnt_d = flush_cnt_q + FW'(1);
                    end
                end
            end
            DRAIN: begin
                if (out_cnt_q == '0) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            out_cnt_q   <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            out_cnt_q   <= out_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign m_trunc    = f_res[OWIDTH-2 -: DWIDTH];
    assign unused_res = ^f_res;

`ifdef FIR_CTRL_SAT_EN
    // two sign bits disagree: the realigned product no longer fits in DWIDTH
    always_comb begin
        m_data = m_trunc;
        if (f_res[OWIDTH-1] != f_res[OWIDTH-2]) begin
            m_data = f_res[OWIDTH-1] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}};
        end
    end
`else
    assign m_data = m_trunc;
`endif

endmodule
